lstm_sequencer: RTL and testbench

Sequencing controller for `lstm_layers`. Runs one complete sequence per `start`: zeroes or loads every layer's h/C state, streams `seq_len` x samples into the stack one at a time, and returns each y result on a valid/ready output stream. It tags the last result and captures the final cell state. It sits between a sample source (DMA or AXI register shim) and `lstm_layers`, and replaces per-sample register pokes with a single start command.

---
 rtl/lstm_pkg.sv | 22 ++
 rtl/lstm_out_buffer.sv | 47 ++++
 rtl/lstm_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_lstm_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lstm_pkg : shared types and defaults for the lstm_layers wrappers    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lstm_pkg;

  localparam int c_default_width  = 16;
  localparam int c_default_layers = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } seq_state_t;

  typedef logic signed [c_default_layers-1:0][c_default_width-1:0] lstm_vec_t;

endpackage
`default_nettype wire

// File: rtl/lstm_out_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lstm_out_buffer : single-entry valid/ready register for {last, y}    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lstm_out_buffer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_y,
  input  logic             load_last,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_y,
  output logic             m_last
);

  logic             r_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_last;

  // Data only changes on load, so it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_last  <= 1'b0;
    end else if (clr) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_y     <= load_y;
      r_last  <= load_last;
    end else if (r_valid && m_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign m_valid = r_valid;
  assign m_y     = r_y;
  assign m_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/lstm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lstm_sequencer : runs one full sequence through lstm_layers per start |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lstm_sequencer
  import lstm_pkg::*;
#(
  parameter int LAYERS    = c_default_layers,
  parameter int WIDTH     = c_default_width,
  parameter int LEN_WIDTH = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [LEN_WIDTH-1:0]         seq_len,
  input  logic                         init_load,
  input  logic [LAYERS-1:0][WIDTH-1:0] h_init,
  input  logic [LAYERS-1:0][WIDTH-1:0] C_init,
  input  logic [WIDTH-1:0]             s_x,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [WIDTH-1:0]             m_y,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  input  logic                         lstm_ready,
  output logic [LAYERS-1:0][WIDTH-1:0] lstm_h_in,
  output logic [LAYERS-1:0][WIDTH-1:0] lstm_C_in,
  output logic [LAYERS-1:0]            lstm_h_in_valid,
  output logic [LAYERS-1:0]            lstm_C_in_valid,
  output logic [WIDTH-1:0]             lstm_x_in,
  output logic                         lstm_x_in_valid,
  input  logic [WIDTH-1:0]             lstm_y_out,
  input  logic [WIDTH-1:0]             lstm_C_out,
  input  logic                         lstm_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err,
  output logic [WIDTH-1:0]             C_final
);

  localparam int c_layer_w = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int c_wdog_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t           r_state;
  seq_state_t           w_state_next;
  logic [LEN_WIDTH-1:0] r_seq_len;
  logic [LEN_WIDTH-1:0] r_step;
  logic                 r_init_load;
  logic [c_layer_w-1:0] r_layer;
  logic [c_wdog_w-1:0]  r_wdog;
  logic                 r_done;
  logic                 r_timeout_err;
  logic [WIDTH-1:0]     r_x_in;
  logic                 r_x_in_valid;
  logic [WIDTH-1:0]     r_C_final;

  logic w_accept;
  logic w_zero_start;
  logic w_issue;
  logic w_result;
  logic w_timeout;
  logic w_drain_done;
  logic w_last;
  logic w_buf_clr;

  assign w_last  = (r_step == (r_seq_len - LEN_WIDTH'(1)));
  assign s_ready = (r_state == S_ISSUE) && lstm_ready && !m_valid;
  assign busy    = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_zero_start = 1'b0;
    w_issue      = 1'b0;
    w_result     = 1'b0;
    w_timeout    = 1'b0;
    w_drain_done = 1'b0;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (seq_len != '0) begin
              w_accept     = 1'b1;
              w_state_next = S_INIT;
            end else begin
              w_zero_start = 1'b1;
            end
          end
        end
        S_INIT: begin
          if (r_layer == c_layer_w'(LAYERS - 1)) begin
            w_state_next = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (s_valid && s_ready) begin
            w_issue      = 1'b1;
            w_state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          // A result arriving on the expiry cycle takes precedence.
          if (lstm_valid) begin
            w_result     = 1'b1;
            w_state_next = w_last ? S_DRAIN : S_ISSUE;
          end else if (r_wdog == c_wdog_w'(TIMEOUT - 1)) begin
            w_timeout    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (m_valid && m_ready) begin
            w_drain_done = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lstm_h_in_valid = '0;
    lstm_C_in_valid = '0;
    lstm_h_in       = '0;
    lstm_C_in       = '0;
    if (r_state == S_INIT) begin
      lstm_h_in_valid[r_layer] = 1'b1;
      lstm_C_in_valid[r_layer] = 1'b1;
      if (r_init_load) begin
        lstm_h_in = h_init;
        lstm_C_in = C_init;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seq_len     <= '0;
      r_step        <= '0;
      r_init_load   <= 1'b0;
      r_layer       <= '0;
      r_wdog        <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_x_in        <= '0;
      r_x_in_valid  <= 1'b0;
      r_C_final     <= '0;
    end else begin
      r_done       <= w_zero_start | w_timeout | w_drain_done;
      r_x_in_valid <= w_issue;
      r_layer      <= (r_state == S_INIT) ? r_layer + c_layer_w'(1) : '0;
      r_wdog       <= (r_state == S_WAIT) ? r_wdog + c_wdog_w'(1) : '0;
      if (w_issue) begin
        r_x_in <= s_x;
      end
      if (w_accept) begin
        r_seq_len     <= seq_len;
        r_init_load   <= init_load;
        r_step        <= '0;
        r_timeout_err <= 1'b0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
      if (w_result) begin
        r_step <= r_step + LEN_WIDTH'(1);
        if (w_last) begin
          r_C_final <= lstm_C_out;
        end
      end
    end
  end

  assign w_buf_clr = abort | w_timeout;

  lstm_out_buffer #(
    .WIDTH (WIDTH)
  ) u_out_buffer (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_buf_clr),
    .load      (w_result),
    .load_y    (lstm_y_out),
    .load_last (w_last),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_y       (m_y),
    .m_last    (m_last)
  );

  assign done            = r_done;
  assign timeout_err     = r_timeout_err;
  assign lstm_x_in       = r_x_in;
  assign lstm_x_in_valid = r_x_in_valid;
  assign C_final         = r_C_final;

endmodule
`default_nettype wire

// File: tb/tb_lstm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lstm_sequencer : directed bench with a 5-cycle stub stack         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lstm_sequencer;
  import lstm_pkg::*;

  localparam int c_lat = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [15:0]     seq_len;
  logic            init_load;
  lstm_vec_t       h_init;
  lstm_vec_t       C_init;
  logic [15:0]     s_x;
  logic            s_valid;
  logic            s_ready;
  logic [15:0]     m_y;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;
  logic            lstm_ready;
  logic [3:0][15:0] lstm_h_in;
  logic [3:0][15:0] lstm_C_in;
  logic [3:0]      lstm_h_in_valid;
  logic [3:0]      lstm_C_in_valid;
  logic [15:0]     lstm_x_in;
  logic            lstm_x_in_valid;
  logic [15:0]     lstm_y_out;
  logic [15:0]     lstm_C_out;
  logic            lstm_valid;
  logic            busy;
  logic            done;
  logic            timeout_err;
  logic [15:0]     C_final;

  int vectors    = 0;
  int miscompares = 0;

  logic [16:0] outq[$];
  int n_done, n_init, n_xv, n_busy, n_mvalid;
  bit stub_en;
  int stub_cnt;
  logic [15:0] stub_x;

  always #5 clk = ~clk;

  lstm_sequencer #(
    .LAYERS(4), .WIDTH(16), .LEN_WIDTH(16), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_len(seq_len),
    .init_load(init_load), .h_init(h_init), .C_init(C_init),
    .s_x(s_x), .s_valid(s_valid), .s_ready(s_ready),
    .m_y(m_y), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .lstm_ready(lstm_ready), .lstm_h_in(lstm_h_in), .lstm_C_in(lstm_C_in),
    .lstm_h_in_valid(lstm_h_in_valid), .lstm_C_in_valid(lstm_C_in_valid),
    .lstm_x_in(lstm_x_in), .lstm_x_in_valid(lstm_x_in_valid),
    .lstm_y_out(lstm_y_out), .lstm_C_out(lstm_C_out), .lstm_valid(lstm_valid),
    .busy(busy), .done(done), .timeout_err(timeout_err), .C_final(C_final)
  );

  // Stub stack: y = x + 1, C = x + 0x1000, after a fixed latency.
  always @(posedge clk) begin
    lstm_valid <= 1'b0;
    if (lstm_x_in_valid) begin
      stub_x   <= lstm_x_in;
      stub_cnt <= c_lat;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && stub_en) begin
        lstm_valid <= 1'b1;
        lstm_y_out <= stub_x + 16'h0001;
        lstm_C_out <= stub_x + 16'h1000;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid && m_ready) outq.push_back({m_last, m_y});
    if (done) n_done++;
    if ((|lstm_h_in_valid) || (|lstm_C_in_valid)) n_init++;
    if (lstm_x_in_valid) n_xv++;
    if (busy) n_busy++;
    if (m_valid) n_mvalid++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    outq.delete();
    n_done = 0; n_init = 0; n_xv = 0; n_busy = 0; n_mvalid = 0;
  endtask

  task automatic pulse_start(input logic [15:0] len, input logic ld);
    seq_len = len; init_load = ld; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] x);
    bit ok = 0;
    s_x = x; s_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (s_ready) ok = 1;
      tick();
    end
    s_valid = 1'b0;
    check("send_handshake", {31'd0, ok}, 32'd1);
    check("x_in_valid", {31'd0, lstm_x_in_valid}, 32'd1);
    check("x_in", {16'd0, lstm_x_in}, {16'd0, x});
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 500 && !ok; k++) begin
      tick();
      if (done) ok = 1;
    end
    check("done_seen", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int bad;
    rst = 1'b0; start = 1'b0; abort = 1'b0; seq_len = '0; init_load = 1'b0;
    h_init = {16'sd4, 16'sd3, 16'sd2, 16'sd1};
    C_init = {16'sd8, 16'sd7, 16'sd6, 16'sd5};
    s_x = '0; s_valid = 1'b0; m_ready = 1'b1; lstm_ready = 1'b1;
    stub_en = 1; stub_cnt = 0; stub_x = '0;
    lstm_y_out = '0; lstm_C_out = '0; lstm_valid = 1'b0;
    clear_mon();
    repeat (3) tick();

    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check("rst_strobes", {26'd0, lstm_h_in_valid, lstm_C_in_valid, lstm_x_in_valid}, 32'd0);
    check("rst_m_y", {16'd0, m_y}, 32'd0);
    check("rst_C_final", {16'd0, C_final}, 32'd0);
    check("rst_x_in", {16'd0, lstm_x_in}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic 3-step sequence with zeroed state.
    clear_mon();
    pulse_start(16'd3, 1'b0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("t1_h_strobe", {28'd0, lstm_h_in_valid}, 32'd1 << i);
      check("t1_C_strobe", {28'd0, lstm_C_in_valid}, 32'd1 << i);
      check("t1_h_zero", {16'd0, lstm_h_in[i]}, 32'd0);
      check("t1_C_zero", {16'd0, lstm_C_in[i]}, 32'd0);
      tick();
    end
    check("t1_init_over", {28'd0, lstm_h_in_valid}, 32'd0);
    check("t1_issue_ready", {31'd0, s_ready}, 32'd1);
    send(16'h0100);
    send(16'h0200);
    send(16'h0300);
    wait_done();
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_n_out", outq.size(), 32'd3);
    check("t1_y0", {15'd0, outq[0]}, 32'h00101);
    check("t1_y1", {15'd0, outq[1]}, 32'h00201);
    check("t1_y2", {15'd0, outq[2]}, 32'h10301);
    check("t1_C_final", {16'd0, C_final}, 32'h1300);
    tick();
    check("t1_n_done", n_done, 32'd1);
    check("t1_n_init", n_init, 32'd4);

    // Zero-length start.
    clear_mon();
    pulse_start(16'd0, 1'b0);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t2_done_low", {31'd0, done}, 32'd0);
    repeat (3) tick();
    check("t2_n_init", n_init, 32'd0);
    check("t2_n_xv", n_xv, 32'd0);
    check("t2_n_busy", n_busy, 32'd0);

    // Downstream stall after the first result.
    clear_mon();
    m_ready = 1'b0;
    pulse_start(16'd3, 1'b0);
    send(16'h0A00);
    bad = 1;
    for (int k = 0; k < 100 && bad != 0; k++) begin
      if (m_valid) bad = 0; else tick();
    end
    check("t3_m_valid_up", bad, 32'd0);
    bad = 0;
    s_valid = 1'b1; s_x = 16'h0B00;
    for (int k = 0; k < 20; k++) begin
      if (s_ready || !m_valid || m_y !== 16'h0A01) bad++;
      tick();
    end
    s_valid = 1'b0;
    check("t3_stall_stable", bad, 32'd0);
    m_ready = 1'b1;
    send(16'h0B00);
    send(16'h0C00);
    wait_done();
    check("t3_n_out", outq.size(), 32'd3);
    check("t3_y0", {15'd0, outq[0]}, 32'h00A01);
    check("t3_y1", {15'd0, outq[1]}, 32'h00B01);
    check("t3_y2", {15'd0, outq[2]}, 32'h10C01);

    // Watchdog: stub silent, TIMEOUT = 16.
    clear_mon();
    stub_en = 0;
    pulse_start(16'd2, 1'b0);
    send(16'h0100);
    repeat (15) tick();
    check("t4_done_early", {31'd0, done}, 32'd0);
    check("t4_err_early", {31'd0, timeout_err}, 32'd0);
    tick();
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_err", {31'd0, timeout_err}, 32'd1);
    tick();
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_m_valid", {31'd0, m_valid}, 32'd0);
    check("t4_err_sticky", {31'd0, timeout_err}, 32'd1);
    stub_en = 1;
    tick();
    pulse_start(16'd1, 1'b0);
    check("t4_err_cleared", {31'd0, timeout_err}, 32'd0);
    send(16'h0700);
    wait_done();
    check("t4_len1_out", {15'd0, outq[0]}, 32'h10701);
    check("t4_len1_C", {16'd0, C_final}, 32'h1700);

    // Abort in WAIT of step 1 of 4.
    tick();
    clear_mon();
    pulse_start(16'd4, 1'b0);
    send(16'h0100);
    send(16'h0200);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle", {31'd0, busy}, 32'd0);
    check("t5_m_valid", {31'd0, m_valid}, 32'd0);
    n_mvalid = 0;
    repeat (20) tick();
    check("t5_no_late_out", n_mvalid, 32'd0);
    check("t5_no_done", n_done, 32'd0);
    check("t5_n_out", outq.size(), 32'd1);

    // Loaded initial state.
    clear_mon();
    pulse_start(16'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t6_h_strobe", {28'd0, lstm_h_in_valid}, 32'd1 << i);
      check("t6_C_strobe", {28'd0, lstm_C_in_valid}, 32'd1 << i);
      check("t6_h_val", {16'd0, lstm_h_in[i]}, i + 1);
      check("t6_C_val", {16'd0, lstm_C_in[i]}, i + 5);
      tick();
    end
    send(16'h0040);
    wait_done();
    check("t6_out", {15'd0, outq[0]}, 32'h10041);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
